// File: rtl/cache_pkg.sv
// Shared cache definitions: default geometry and one-hot way encodings.
package cache_pkg;
    localparam int DEF_INDEX_W = 8;
    localparam int DEF_TAG_W   = 20;

    typedef logic [1:0] way_t;

    localparam way_t WAY_NONE = 2'b00;
    localparam way_t WAY1     = 2'b01;
    localparam way_t WAY2     = 2'b10;
endpackage

// File: rtl/lru_table.sv
// Per-set LRU bits (1 = way 1 most recently used, so way 2 is the victim).
// Combinational read; hit and refill writes land on the rising edge, refill wins on a set collision.
module lru_table #(
    parameter int INDEX_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INDEX_W-1:0] rd_index,
    output logic               rd_lru,
    input  logic               hit_we,
    input  logic [INDEX_W-1:0] hit_index,
    input  logic               hit_lru,
    input  logic               fill_we,
    input  logic [INDEX_W-1:0] fill_index,
    input  logic               fill_lru
);
    localparam int SETS = 1 << INDEX_W;

    logic [SETS-1:0] lru;

    assign rd_lru = lru[rd_index];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lru <= '0;
        end else begin
            if (hit_we && !(fill_we && (fill_index == hit_index))) begin
                lru[hit_index] <= hit_lru;
            end
            if (fill_we) begin
                lru[fill_index] <= fill_lru;
            end
        end
    end
endmodule

// File: rtl/hit_gen_lru.sv
// Two-way tag compare stage: one-hot hit, miss and victim one cycle after a request is accepted.
// Define HIT_GEN_LRU_EN for a per-set LRU table; otherwise a global refill toggle picks the victim.
module hit_gen_lru
    import cache_pkg::*;
#(
    parameter int INDEX_W = DEF_INDEX_W,
    parameter int TAG_W   = DEF_TAG_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    input  logic [INDEX_W-1:0] req_index,
    input  logic [TAG_W-1:0]   req_tag,
    input  logic               req_uncached,
    input  logic               stall,
    input  logic [TAG_W-1:0]   tag1,
    input  logic [TAG_W-1:0]   tag2,
    input  logic               v1,
    input  logic               v2,
    input  logic               refill_done,
    input  logic [INDEX_W-1:0] refill_index,
    input  way_t               refill_way,
    output way_t               hit,
    output logic               lookup_valid,
    output logic               miss,
    output way_t               victim,
    output logic               multihit_err
);
    logic               s_valid;
    logic               s_uncached;
    logic [INDEX_W-1:0] s_index;
    logic [TAG_W-1:0]   s_tag;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_valid    <= 1'b0;
            s_uncached <= 1'b0;
            s_index    <= '0;
            s_tag      <= '0;
        end else if (!stall) begin
            s_valid    <= req_valid;
            s_uncached <= req_uncached;
            s_index    <= req_index;
            s_tag      <= req_tag;
        end
    end

    logic match1;
    logic match2;
    logic policy_way2;

    assign match1       = s_valid & ~s_uncached & v1 & (tag1 == s_tag);
    assign match2       = s_valid & ~s_uncached & v2 & (tag2 == s_tag);
    assign hit          = {match2, match1};
    assign lookup_valid = s_valid;
    assign miss         = s_valid & ~match1 & ~match2;
    assign multihit_err = match1 & match2;

    // Invalid ways are filled first; recency only matters when both are valid.
    always_comb begin
        victim = policy_way2 ? WAY2 : WAY1;
        if (!v1) begin
            victim = WAY1;
        end else if (!v2) begin
            victim = WAY2;
        end
    end

`ifdef HIT_GEN_LRU_EN
    logic hit_we;
    logic fill_we;

    // A double hit is an error, not a recency event.
    assign hit_we  = ~stall & (match1 ^ match2);
    assign fill_we = refill_done & (refill_way[0] ^ refill_way[1]);

    lru_table #(
        .INDEX_W(INDEX_W)
    ) u_lru_table (
        .clk        (clk),
        .rst        (rst),
        .rd_index   (s_index),
        .rd_lru     (policy_way2),
        .hit_we     (hit_we),
        .hit_index  (s_index),
        .hit_lru    (match1),
        .fill_we    (fill_we),
        .fill_index (refill_index),
        .fill_lru   (refill_way[0])
    );
`else
    logic toggle;
    logic unused_refill;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            toggle <= 1'b0;
        end else if (refill_done) begin
            toggle <= ~toggle;
        end
    end

    assign policy_way2   = toggle;
    assign unused_refill = ^{refill_index, refill_way};
`endif
endmodule

// File: tb/tb_hit_gen_lru.sv
// Bench for hit_gen_lru: directed scenarios plus random traffic against a recency/refill-count model.
module tb_hit_gen_lru;
    logic        clk;
    logic        rst;
    logic        req_valid;
    logic [7:0]  req_index;
    logic [19:0] req_tag;
    logic        req_uncached;
    logic        stall;
    logic [19:0] tag1;
    logic [19:0] tag2;
    logic        v1;
    logic        v2;
    logic        refill_done;
    logic [7:0]  refill_index;
    logic [1:0]  refill_way;
    logic [1:0]  hit;
    logic        lookup_valid;
    logic        miss;
    logic [1:0]  victim;
    logic        multihit_err;

    hit_gen_lru #(.INDEX_W(8), .TAG_W(20)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_index    (req_index),
        .req_tag      (req_tag),
        .req_uncached (req_uncached),
        .stall        (stall),
        .tag1         (tag1),
        .tag2         (tag2),
        .v1           (v1),
        .v2           (v2),
        .refill_done  (refill_done),
        .refill_index (refill_index),
        .refill_way   (refill_way),
        .hit          (hit),
        .lookup_valid (lookup_valid),
        .miss         (miss),
        .victim       (victim),
        .multihit_err (multihit_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Model: pending lookup, which way each set should replace next, and refills seen since reset.
    logic        m_valid;
    logic        m_unc;
    logic [7:0]  m_index;
    logic [19:0] m_tag;
    int          lru_way [256];
    int          refills;

    logic [1:0]  obs_hit;
    logic        obs_miss;
    logic [1:0]  obs_victim;
    logic        obs_mh;
    logic [19:0] pool [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic int policy_way(input logic [7:0] idx);
`ifdef HIT_GEN_LRU_EN
        return lru_way[idx];
`else
        return (refills % 2 == 0) ? 1 : 2;
`endif
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_unc   = 1'b0;
        m_index = '0;
        m_tag   = '0;
        refills = 0;
        for (int i = 0; i < 256; i++) lru_way[i] = 1;
    endtask

    task automatic step(input logic rv, input logic [7:0] ri, input logic [19:0] rt, input logic ru,
                        input logic st, input logic [19:0] t1, input logic [19:0] t2,
                        input logic a1, input logic a2,
                        input logic rd, input logic [7:0] rfi, input logic [1:0] rfw);
        logic e1;
        logic e2;
        int   vw;
        @(negedge clk);
        req_valid = rv; req_index = ri; req_tag = rt; req_uncached = ru; stall = st;
        tag1 = t1; tag2 = t2; v1 = a1; v2 = a2;
        refill_done = rd; refill_index = rfi; refill_way = rfw;
        #1;
        e1 = m_valid && !m_unc && a1 && (t1 == m_tag);
        e2 = m_valid && !m_unc && a2 && (t2 == m_tag);
        obs_hit = hit; obs_miss = miss; obs_victim = victim; obs_mh = multihit_err;
        chk("hit", hit, {e2, e1});
        chk("miss", miss, m_valid && !e1 && !e2);
        chk("lookup_valid", lookup_valid, m_valid);
        chk("multihit_err", multihit_err, e1 && e2);
        if (m_valid) begin
            vw = !a1 ? 1 : (!a2 ? 2 : policy_way(m_index));
            chk("victim", victim, (vw == 1) ? 2'b01 : 2'b10);
        end
        @(posedge clk);
        if (!st && (e1 != e2)) lru_way[m_index] = e1 ? 2 : 1;
        if (rd) begin
            lru_way[rfi] = (rfw == 2'b01) ? 2 : 1;
            refills++;
        end
        if (!st) begin
            m_valid = rv; m_index = ri; m_tag = rt; m_unc = ru;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        req_valid = 0; req_index = 0; req_tag = 0; req_uncached = 0; stall = 0; refill_done = 0;
        #2 rst = 1'b1;
        #1;
        chk("rst_lookup_valid", lookup_valid, 1'b0);
        chk("rst_hit", hit, 2'b00);
        chk("rst_miss", miss, 1'b0);
        chk("rst_multihit", multihit_err, 1'b0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 0; req_index = 0; req_tag = 0; req_uncached = 0; stall = 0;
        tag1 = 0; tag2 = 0; v1 = 0; v2 = 0; refill_done = 0; refill_index = 0; refill_way = 0;
        pool[0] = 20'h0A0A0; pool[1] = 20'h12345; pool[2] = 20'hFFFFF; pool[3] = 20'h00001;
        model_reset();
        #1;
        chk("init_lookup_valid", lookup_valid, 1'b0);
        chk("init_hit", hit, 2'b00);
        chk("init_miss", miss, 1'b0);
        chk("init_multihit", multihit_err, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Way-2 hit on set 0x12, then a mismatched lookup of the same set.
        step(1, 8'h12, 20'hABCDE, 0, 0, 20'h0, 20'h0, 0, 0, 0, 8'h0, 2'b00);
        step(1, 8'h12, 20'h11111, 0, 0, 20'h00001, 20'hABCDE, 1, 1, 0, 8'h0, 2'b00);
        chk("d_hit_way2", obs_hit, 2'b10);
        chk("d_hit_way2_miss", obs_miss, 1'b0);
        step(0, 8'h0, 20'h0, 0, 0, 20'h22222, 20'h33333, 1, 1, 0, 8'h0, 2'b00);
        chk("d_victim_after_way2", obs_victim, 2'b01);
        chk("d_miss_after_way2", obs_miss, 1'b1);

        // Invalid way 2 is preferred.
        step(1, 8'h20, 20'h44444, 0, 0, 20'h0, 20'h0, 0, 0, 0, 8'h0, 2'b00);
        step(0, 8'h0, 20'h0, 0, 0, 20'h55555, 20'h66666, 1, 0, 0, 8'h0, 2'b00);
        chk("d_inv_hit", obs_hit, 2'b00);
        chk("d_inv_miss", obs_miss, 1'b1);
        chk("d_inv_victim", obs_victim, 2'b10);

        // Multi-hit, then the same lookup uncached, then confirm LRU untouched.
        step(1, 8'h30, 20'h77777, 0, 0, 20'h0, 20'h0, 0, 0, 0, 8'h0, 2'b00);
        step(1, 8'h30, 20'h77777, 1, 0, 20'h77777, 20'h77777, 1, 1, 0, 8'h0, 2'b00);
        chk("d_mh_hit", obs_hit, 2'b11);
        chk("d_mh_err", obs_mh, 1'b1);
        step(1, 8'h30, 20'h00002, 0, 0, 20'h77777, 20'h77777, 1, 1, 0, 8'h0, 2'b00);
        chk("d_unc_hit", obs_hit, 2'b00);
        chk("d_unc_miss", obs_miss, 1'b1);
        step(0, 8'h0, 20'h0, 0, 0, 20'h00003, 20'h00004, 1, 1, 0, 8'h0, 2'b00);
        chk("d_mh_lru_unchanged", obs_victim, 2'b01);

        // Three stall cycles hold a way-1 hit; the recency update lands when stall drops.
        step(1, 8'h40, 20'h88888, 0, 0, 20'h0, 20'h0, 0, 0, 0, 8'h0, 2'b00);
        for (int i = 0; i < 3; i++) begin
            step(0, 8'h0, 20'h0, 0, 1, 20'h88888, 20'h0, 1, 1, 0, 8'h0, 2'b00);
            chk("d_stall_hold", obs_hit, 2'b01);
        end
        step(1, 8'h40, 20'h12340, 0, 0, 20'h88888, 20'h0, 1, 1, 0, 8'h0, 2'b00);
        chk("d_stall_release", obs_hit, 2'b01);
        step(0, 8'h0, 20'h0, 0, 0, 20'h00005, 20'h00006, 1, 1, 0, 8'h0, 2'b00);
`ifdef HIT_GEN_LRU_EN
        chk("d_stall_victim", obs_victim, 2'b10);
`else
        chk("d_stall_victim", obs_victim, 2'b01);
`endif

        // Way-1 hit on set 5 collides with a way-2 refill of set 5.
        step(1, 8'h05, 20'h99999, 0, 0, 20'h0, 20'h0, 0, 0, 0, 8'h0, 2'b00);
        step(1, 8'h05, 20'hAAAAA, 0, 0, 20'h99999, 20'h0, 1, 1, 1, 8'h05, 2'b10);
        chk("d_coll_hit", obs_hit, 2'b01);
        step(0, 8'h0, 20'h0, 0, 0, 20'h00007, 20'h00008, 1, 1, 0, 8'h0, 2'b00);
`ifdef HIT_GEN_LRU_EN
        chk("d_coll_victim", obs_victim, 2'b01);
`else
        chk("d_coll_victim", obs_victim, 2'b10);
`endif

        // Reset with a way-1 hit pending; replacement state returns to way 1 everywhere.
        step(1, 8'h05, 20'h99999, 0, 0, 20'h0, 20'h0, 0, 0, 0, 8'h0, 2'b00);
        tag1 = 20'h99999; v1 = 1; v2 = 1;
        do_reset();
        step(1, 8'h40, 20'h00009, 0, 0, 20'h0, 20'h0, 0, 0, 0, 8'h0, 2'b00);
        step(1, 8'h05, 20'h0000A, 0, 0, 20'h00001, 20'h00002, 1, 1, 0, 8'h0, 2'b00);
        chk("d_rst_victim_40", obs_victim, 2'b01);
        step(0, 8'h0, 20'h0, 0, 0, 20'h00001, 20'h00002, 1, 1, 0, 8'h0, 2'b00);
        chk("d_rst_victim_05", obs_victim, 2'b01);

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 3) != 0,
                     8'($urandom_range(0, 7)),
                     pool[$urandom_range(0, 3)],
                     $urandom_range(0, 7) == 0,
                     $urandom_range(0, 4) == 0,
                     $urandom_range(0, 1) ? m_tag : pool[$urandom_range(0, 3)],
                     $urandom_range(0, 1) ? m_tag : pool[$urandom_range(0, 3)],
                     $urandom_range(0, 3) != 0,
                     $urandom_range(0, 3) != 0,
                     $urandom_range(0, 5) == 0,
                     8'($urandom_range(0, 7)),
                     $urandom_range(0, 1) ? 2'b01 : 2'b10);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/hit_gen_lru.md
HIT_GEN_LRU -- requirements
Module: hit_gen_lru

Interface
REQ-001 Parameter: INDEX_W, default 8, set index width (256 sets).
REQ-002 Parameter: TAG_W, default 20, physical tag width.
REQ-003 Port: clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous and active-high.
REQ-005 Port: req_valid  input  1  lookup request accepted this cycle when stall=0.
REQ-006 Port: req_index  input  INDEX_W  set index, also presented to the tag RAMs.
REQ-007 Port: req_tag  input  TAG_W  lookup tag.
REQ-008 Port: req_uncached  input  1  uncached access, never hits.
REQ-009 Port: stall  input  1  holds the stage register and suppresses LRU updates.
REQ-010 Port: tag1, tag2  input  TAG_W each  way-1 and way-2 tag RAM read data, valid one cycle after the index.
REQ-011 Port: v1, v2  input  1 each  way valid bits, same timing as tag1 and tag2.
REQ-012 Port: refill_done  input  1  line refill completed this cycle.
REQ-013 Port: refill_index  input  INDEX_W  set index of the refilled line.
REQ-014 Port: refill_way  input  2  refilled way, one-hot.
REQ-015 Port: hit  output  2  one-hot hit vector for the way-data selector (01 = way 1, 10 = way 2, 00 = miss).
REQ-016 Port: lookup_valid  output  1  hit, miss and victim are meaningful this cycle.
REQ-017 Port: miss  output  1  lookup_valid and hit==00.
REQ-018 Port: victim  output  2  one-hot way to replace on a miss.
REQ-019 Port: multihit_err  output  1  both ways matched.

Function
REQ-020 Stage register: when stall=0, on each edge capture req_valid, req_index, req_tag and req_uncached; when stall=1, hold all four.
REQ-021 Latency: a request accepted at edge T produces hit, miss and victim during cycle T+1, derived combinationally from the stage register, tag1/tag2 and v1/v2.
REQ-022 Tag compare per way:
  - hit[0] = s_valid & ~s_uncached & v1 & (tag1==s_tag).
  - hit[1] is the same expression for way 2.
REQ-023 lookup_valid equals the stage-register valid bit.
REQ-024 When lookup_valid=0, hit=00 and miss=0.
REQ-025 Multi-hit: when both ways match, hit=11 is passed through unchanged and multihit_err=1 for that cycle.
REQ-026 Victim selection, in priority order:
  - v1=0 gives 01.
  - otherwise v2=0 gives 10.
  - otherwise the LRU policy decides.
REQ-027 LRU state: one bit per set, lru[s]=0 means way 1 is least recently used.
REQ-028 LRU victim: 01 when lru[s]=0, otherwise 10.
REQ-029 LRU update on hit, at the edge ending cycle T+1 when stall=0:
  - hit=01 sets lru[s_index]=1.
  - hit=10 sets lru[s_index]=0.
  - hit=11 and uncached accesses leave the LRU unchanged.
REQ-030 LRU update on refill: refill_done marks refill_way as most recently used in lru[refill_index]; this update is not gated by stall.
REQ-031 Collision: when a hit update and a refill update target the same set in the same cycle, the refill update wins.
REQ-032 Refill read-during-write: the refill update is visible to a lookup of the same set in the following cycle.

Reset
REQ-033 While rst=1, immediately and asynchronously:
  - stage valid=0, therefore hit=00, miss=0 and lookup_valid=0;
  - multihit_err=0;
  - all LRU bits=0, the replacement toggle=0, and the stage tag/index registers=0.
REQ-034 A reset asserted mid-lookup discards the pending lookup with no LRU update.

Configuration
REQ-035 The macro HIT_GEN_LRU_EN selects the replacement policy.
REQ-036 With HIT_GEN_LRU_EN defined, the per-set LRU table is used as described in REQ-027 to REQ-031.
REQ-037 Without HIT_GEN_LRU_EN, no LRU table is built; the policy step of REQ-026 uses a single global bit:
  - the bit toggles on every refill_done;
  - victim is 01 when the bit is 0, otherwise 10;
  - all other behaviour is identical.

Structure
REQ-038 The shared package cache_pkg holds:
  - TAG_W and INDEX_W defaults;
  - way one-hot constants WAY_NONE=00, WAY1=01, WAY2=10;
  - a typedef for the 2-bit way vector.
REQ-039 One sub-module, lru_table, contains the LRU storage:
  - one read port plus hit and refill write ports with the priority of REQ-031;
  - present only when HIT_GEN_LRU_EN is defined.

Verification
REQ-040 Hit way 2: request index 0x12, tag 0xABCDE, with next-cycle tag2=0xABCDE and v1=v2=1 -> hit=10, miss=0; on the next lookup of 0x12 with both ways valid and mismatched, victim=01.
REQ-041 Miss, invalid way preferred: v1=1, v2=0, tags mismatch -> hit=00, miss=1, victim=10 regardless of the LRU bit.
REQ-042 Multi-hit and uncached:
  - tag1=tag2=req_tag with both ways valid -> hit=11, multihit_err=1, LRU unchanged;
  - the same lookup with req_uncached=1 -> hit=00, miss=1.
REQ-043 Stall: assert stall for 3 cycles after accepting a request -> hit is held stable for all 3 cycles and no LRU change occurs until stall drops.
REQ-044 Collision and reset:
  - a hit of way 1 on set 5 coincides with refill_done on set 5 for way 2 -> lru[5]=0 afterwards;
  - asserting rst mid-lookup -> lookup_valid=0 immediately and all LRU bits read 0.
